// File: rtl/nco_phase_fold_pkg.sv
// rtl/nco_phase_fold_pkg.sv - shared fold widths and helpers for the NCO phase path and cosine stage
package nco_phase_fold_pkg;

    localparam int ROM_AW = 10;
    localparam int FRAC_W = 14;
    localparam int FOLD_W = ROM_AW + FRAC_W;

    // Fields that travel alongside the ROM read so they meet rom_d in the same cycle.
    typedef struct packed {
        logic [FRAC_W-1:0] a;
        logic              s;
        logic              v;
    } tail_t;

    localparam tail_t TAIL_RST = '{a: '0, s: 1'b1, v: 1'b0};

    // Ones' complement mirror for odd quadrants; the half-LSB error is accepted.
    function automatic logic [FOLD_W-1:0] fold_mirror(input logic [FOLD_W-1:0] x,
                                                      input logic              m);
        return m ? ~x : x;
    endfunction

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - fixed-depth shift register with synchronous reset value and no enable
module delay_line #(
    parameter int             W       = 16,
    parameter int             DEPTH   = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         c,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stg [DEPTH];

    always_ff @(posedge c) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= RST_VAL;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/nco_phase_fold.sv
// rtl/nco_phase_fold.sv - phase accumulator, offset, quadrant fold and ROM-latency alignment
module nco_phase_fold
    import nco_phase_fold_pkg::*;
#(
    parameter int NBP     = 32,
    parameter int ROM_LAT = 2
) (
    input  logic              c,
    input  logic              rst_n,
    input  logic              en,
    input  logic              ftw_wr,
    input  logic [NBP-1:0]    ftw_in,
    input  logic              poff_wr,
    input  logic [NBP-1:0]    poff_in,
    input  logic              sync,
    input  logic              sync_clr,
    output logic              pend,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [FRAC_W-1:0] a,
    output logic              s,
    output logic              v
);

    logic [NBP-1:0]    acc;
    logic [NBP-1:0]    ftw_act;
    logic [NBP-1:0]    ftw_pend;
    logic [NBP-1:0]    poff;
    logic [NBP-1:0]    ph;
    logic              v0;
    logic              v1;
    logic              v2;
    logic              s2;
    logic [FRAC_W-1:0] a2;

    logic [1:0]        q;
    logic [FOLD_W-1:0] x;
    logic [FOLD_W-1:0] xm;
    tail_t             tail_in;
    tail_t             tail_out;

    assign q  = ph[NBP-1 -: 2];
    assign x  = ph[NBP-3 -: FOLD_W];
    assign xm = fold_mirror(x, q[0]);

    generate
        if (NBP > 26) begin : g_trunc
            logic unused_ph_lsbs;
            assign unused_ph_lsbs = ^ph[NBP-27:0];
        end
    endgenerate

    always_ff @(posedge c) begin
        if (!rst_n) begin
            acc      <= '0;
            ftw_act  <= '0;
            ftw_pend <= '0;
            poff     <= '0;
            ph       <= '0;
            pend     <= 1'b0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            s2       <= 1'b1;
            a2       <= '0;
            rom_addr <= '0;
        end else begin
            if (ftw_wr) begin
                ftw_pend <= ftw_in;
            end
            // A write in the same cycle as sync wins the pending flag: the new word is still unapplied.
            if (ftw_wr) begin
                pend <= 1'b1;
            end else if (sync) begin
                pend <= 1'b0;
            end
            if (sync) begin
                ftw_act <= ftw_pend;
            end
            if (poff_wr) begin
                poff <= poff_in;
            end

            if (sync && sync_clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + ftw_act;
            end
            v0 <= en;

            ph <= acc + poff;
            v1 <= v0;

            rom_addr <= xm[FOLD_W-1 -: ROM_AW];
            a2       <= xm[FRAC_W-1:0];
            s2       <= ~(q[1] ^ q[0]);
            v2       <= v1;
        end
    end

    assign tail_in = '{a: a2, s: s2, v: v2};

    delay_line #(
        .W       ($bits(tail_t)),
        .DEPTH   (ROM_LAT),
        .RST_VAL (TAIL_RST)
    ) u_align (
        .c     (c),
        .rst_n (rst_n),
        .d     (tail_in),
        .q     (tail_out)
    );

    assign a = tail_out.a;
    assign s = tail_out.s;
    assign v = tail_out.v;

endmodule

// File: tb/tb_nco_phase_fold.sv
// tb/tb_nco_phase_fold.sv - directed self-checking bench for nco_phase_fold at ROM_LAT 2 and 4
module tb_nco_phase_fold;

    logic        c = 1'b0;
    logic        rst_n;
    logic        en;
    logic        ftw_wr;
    logic [31:0] ftw_in;
    logic        poff_wr;
    logic [31:0] poff_in;
    logic        sync;
    logic        sync_clr;

    logic        pend,  pend4;
    logic [9:0]  rom_addr, rom_addr4;
    logic [13:0] a, a4;
    logic        s, s4;
    logic        v, v4;

    int errors = 0;
    int checks = 0;

    always #5 c = ~c;

    nco_phase_fold #(.NBP(32), .ROM_LAT(2)) dut (
        .c(c), .rst_n(rst_n), .en(en), .ftw_wr(ftw_wr), .ftw_in(ftw_in),
        .poff_wr(poff_wr), .poff_in(poff_in), .sync(sync), .sync_clr(sync_clr),
        .pend(pend), .rom_addr(rom_addr), .a(a), .s(s), .v(v)
    );

    nco_phase_fold #(.NBP(32), .ROM_LAT(4)) dut4 (
        .c(c), .rst_n(rst_n), .en(en), .ftw_wr(ftw_wr), .ftw_in(ftw_in),
        .poff_wr(poff_wr), .poff_in(poff_in), .sync(sync), .sync_clr(sync_clr),
        .pend(pend4), .rom_addr(rom_addr4), .a(a4), .s(s4), .v(v4)
    );

    typedef struct {
        logic [31:0] poff;
        logic [9:0]  rom;
        logic [13:0] fa;
        logic        fs;
    } fold_vec_t;

    fold_vec_t tbl [9];

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 10'h000, 14'h0000, 1'b1};
        tbl[1] = '{32'h4000_0000, 10'h3FF, 14'h3FFF, 1'b0};
        tbl[2] = '{32'h8000_0000, 10'h000, 14'h0000, 1'b0};
        tbl[3] = '{32'hC000_0000, 10'h3FF, 14'h3FFF, 1'b1};
        tbl[4] = '{32'h1234_5678, 10'h123, 14'h1159, 1'b1};
        tbl[5] = '{32'h7FFF_FFC0, 10'h000, 14'h0000, 1'b0};
        tbl[6] = '{32'h5000_0000, 10'h2FF, 14'h3FFF, 1'b0};
        tbl[7] = '{32'hA000_0000, 10'h200, 14'h0000, 1'b0};
        tbl[8] = '{32'h0000_003F, 10'h000, 14'h0000, 1'b1};

        rst_n = 1'b0; en = 1'b0; ftw_wr = 1'b0; ftw_in = '0;
        poff_wr = 1'b0; poff_in = '0; sync = 1'b0; sync_clr = 1'b0;

        repeat (3) step();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_a", a, 0);
        chk("rst_s", s, 1);
        chk("rst_v", v, 0);
        chk("rst_pend", pend, 0);
        chk("rst_s4", s4, 1);
        chk("rst_v4", v4, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            poff_wr = 1'b1; poff_in = tbl[i].poff;
            step();
            poff_wr = 1'b0;
            repeat (7) step();
            chk($sformatf("fold%0d_rom", i), rom_addr, tbl[i].rom);
            chk($sformatf("fold%0d_a", i), a, tbl[i].fa);
            chk($sformatf("fold%0d_s", i), s, tbl[i].fs);
            chk($sformatf("fold%0d_a4", i), a4, tbl[i].fa);
            chk($sformatf("fold%0d_s4", i), s4, tbl[i].fs);
        end
        poff_wr = 1'b1; poff_in = '0;
        step();
        poff_wr = 1'b0;
        repeat (4) step();

        ftw_wr = 1'b1; ftw_in = 32'h0100_0000;
        step();
        ftw_wr = 1'b0;
        chk("ftw_pend_set", pend, 1);
        en = 1'b1;
        repeat (3) step();
        en = 1'b0;
        repeat (6) step();
        chk("ftw_nosync_rom", rom_addr, 0);
        chk("ftw_nosync_a", a, 0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("ftw_sync_pend", pend, 0);
        en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            chk($sformatf("ramp%0d_rom", j), rom_addr, (j == 0) ? 0 : 16 * (j - 1));
            chk($sformatf("ramp%0d_s", j), s, 1);
        end
        en = 1'b0;

        ftw_wr = 1'b1; ftw_in = 32'h0400_0000;
        step();
        ftw_in = 32'h0800_0000; sync = 1'b1; sync_clr = 1'b1;
        step();
        ftw_wr = 1'b0; sync = 1'b0; sync_clr = 1'b0;
        chk("wrsync_pend", pend, 1);
        en = 1'b1;
        step();
        en = 1'b0;
        repeat (4) step();
        chk("wrsync_old_word", rom_addr, 64);
        sync = 1'b1; sync_clr = 1'b1;
        step();
        sync = 1'b0; sync_clr = 1'b0;
        chk("wrsync_pend_clr", pend, 0);
        en = 1'b1;
        step();
        en = 1'b0;
        repeat (4) step();
        chk("wrsync_new_word", rom_addr, 128);

        poff_wr = 1'b1; poff_in = 32'h2345_6789;
        step();
        poff_wr = 1'b0;
        repeat (4) step();
        chk("clr_pre", rom_addr, 10'h2B4);
        sync = 1'b1; sync_clr = 1'b1;
        step();
        sync = 1'b0; sync_clr = 1'b0;
        chk("clr_k0", rom_addr, 10'h2B4);
        step();
        chk("clr_k1", rom_addr, 10'h2B4);
        step();
        chk("clr_k2", rom_addr, 10'h234);

        en = 1'b1;
        step();
        en = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step();
            chk($sformatf("lat2_v%0d", j), v, (j == 4) ? 1 : 0);
            chk($sformatf("lat4_v%0d", j), v4, (j == 6) ? 1 : 0);
        end

        en = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_v", v, 0);
        chk("midrst_v4", v4, 0);
        chk("midrst_rom", rom_addr, 0);
        chk("midrst_s", s, 1);
        for (int j = 1; j <= 7; j++) begin
            step();
            chk($sformatf("midrst_v_%0d", j), v, (j >= 5) ? 1 : 0);
            chk($sformatf("midrst_v4_%0d", j), v4, (j >= 7) ? 1 : 0);
        end
        en = 1'b0;
        repeat (8) step();

        ftw_wr = 1'b1; ftw_in = 32'h8000_0000;
        step();
        ftw_wr = 1'b0; sync = 1'b1; sync_clr = 1'b1;
        step();
        sync = 1'b0; sync_clr = 1'b0;
        en = 1'b1;
        repeat (2) step();
        en = 1'b0;
        step();
        step();
        chk("wrap_s0", s, 1);
        step();
        chk("wrap_s1", s, 0);
        chk("wrap_v1", v, 1);
        step();
        chk("wrap_s2", s, 1);
        chk("wrap_v2", v, 1);
        repeat (4) step();
        chk("wrap_rom_end", rom_addr, 0);
        chk("wrap_s_end", s, 1);
        chk("wrap_v_end", v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
